wl_access_sequencer: RTL and testbench

- Timing controller in front of the 1x16 wordline demux and its extra bank line (WB).
- Accepts one row-access request at a time over a valid/ready handshake and drives the demux address and enable.
- Drives each access through precharge, wordline, sense/write and recovery phases, using parameterised cycle counts.
- Sits between the array-access logic and the demux, precharge, sense-amp and write-driver controls.

---
 rtl/wl_access_sequencer.sv | 83 ++++++++
 tb/tb_wl_access_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wl_access_sequencer.sv
// wl_access_sequencer: precharge/wordline/recovery timing for the 1x16+WB demux; `define WL_BURST_EN for multi-row bursts
module wl_access_sequencer #(
  parameter int T_PRE = 2,
  parameter int T_WL  = 3,
  parameter int T_REC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_addr,
  input  logic       req_wr,
`ifdef WL_BURST_EN
  input  logic [3:0] req_len,
`endif
  output logic [3:0] adr,
  output logic       adr4,
  output logic       in,
  output logic       pre,
  output logic       sae,
  output logic       we,
  output logic       done
);
  localparam logic [1:0] IDLE = 2'd0, PRECH = 2'd1, WLON = 2'd2, RECOV = 2'd3;
  logic [1:0] state, state_n;
  logic [3:0] cnt, cnt_n, ld;
  logic [4:0] addr_n;
  logic       wr, wr_n, hs, phase_end, more, entering;
`ifdef WL_BURST_EN
  logic [3:0] rows, rows_n;
  assign more   = rows != 4'd0;
  assign rows_n = hs ? req_len : (state == RECOV && phase_end && more) ? rows - 4'd1 : rows;
`else
  assign more = 1'b0;
`endif
  always_comb begin
    hs        = req_valid && req_ready && state == IDLE;
    phase_end = cnt == 4'd0;
    state_n   = hs                            ? PRECH :
                state == PRECH && phase_end   ? WLON  :
                state == WLON  && phase_end   ? RECOV :
                state == RECOV && phase_end   ? (more ? PRECH : IDLE) : state;
    entering  = hs || (state != IDLE && phase_end);
    ld        = state_n == PRECH ? 4'(T_PRE - 1) :
                state_n == WLON  ? 4'(T_WL - 1)  :
                state_n == RECOV ? 4'(T_REC - 1) : 4'd0;
    cnt_n     = entering ? ld : state == IDLE ? cnt : cnt - 4'd1;
    // next burst row steps the full 5-bit address, wrapping 31 -> 0
    addr_n    = hs ? req_addr : (state == RECOV && phase_end && more) ? {adr4, adr} + 5'd1 : {adr4, adr};
    wr_n      = hs ? req_wr : wr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr          <= 1'b0;
      {adr4, adr} <= 5'd0;
      req_ready   <= 1'b0;
      pre         <= 1'b0;
      in          <= 1'b0;
      sae         <= 1'b0;
      we          <= 1'b0;
      done        <= 1'b0;
`ifdef WL_BURST_EN
      rows        <= 4'd0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wr          <= wr_n;
      {adr4, adr} <= addr_n;
      req_ready   <= state_n == IDLE;
      pre         <= state_n == PRECH;
      in          <= state_n == WLON;
      we          <= state_n == WLON && wr_n;
      sae         <= state_n == WLON && cnt_n == 4'd0 && !wr_n;
      done        <= state == RECOV && phase_end && !more;
`ifdef WL_BURST_EN
      rows        <= rows_n;
`endif
    end
  end
endmodule

// File: tb/tb_wl_access_sequencer.sv
// tb_wl_access_sequencer: randomized scoreboard bench for wl_access_sequencer
module tb_wl_access_sequencer;
  localparam int T_PRE = 2, T_WL = 3, T_REC = 1;
  localparam int BUSY = T_PRE + T_WL + T_REC;
`ifdef WL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  typedef struct packed {logic pre, in, sae, we, done, ready; logic [4:0] adr;} vec_t;
  typedef struct {logic [4:0] a; logic w; logic [3:0] l;} req_t;
  typedef vec_t vq_t[$];

  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_wr = 1'b0, req_ready;
  logic [4:0] req_addr = 5'd0;
  logic [3:0] req_len_v = 4'd0, adr;
  logic adr4, in, pre, sae, we, done;
  logic f_valid = 1'b0, f_wr = 1'b0, f_ready, f_adr4, f_in, f_pre, f_sae, f_we, f_done;
  logic [4:0] f_addr = 5'd0;
  logic [3:0] f_adr;
  int tests = 0, fails = 0, cyc = 0, last_hs = 0, last_rows = 1;
  bit mon_act = 1'b0;
  logic [4:0] hold_adr = 5'd0;
  req_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wl_access_sequencer #(.T_PRE(T_PRE), .T_WL(T_WL), .T_REC(T_REC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wr(req_wr),
`ifdef WL_BURST_EN
    .req_len(req_len_v),
`endif
    .adr(adr), .adr4(adr4), .in(in), .pre(pre), .sae(sae), .we(we), .done(done));

  wl_access_sequencer #(.T_PRE(1), .T_WL(1), .T_REC(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(f_valid), .req_ready(f_ready),
    .req_addr(f_addr), .req_wr(f_wr),
`ifdef WL_BURST_EN
    .req_len(4'd0),
`endif
    .adr(f_adr), .adr4(f_adr4), .in(f_in), .pre(f_pre), .sae(f_sae), .we(f_we), .done(f_done));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // expected per-cycle outputs of one accepted request, from handshake+1 through the DONE cycle
  function automatic vq_t build(input int tp, input int tw, input int tr, input req_t r);
    vq_t t;
    logic [4:0] a = r.a;
    for (int k = 0; k <= int'(r.l); k++) begin
      for (int i = 0; i < tp; i++) t.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a});
      for (int i = 0; i < tw; i++) t.push_back('{1'b0, 1'b1, !r.w && i == tw - 1, r.w, 1'b0, 1'b0, a});
      for (int i = 0; i < tr; i++) t.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a});
      if (k < int'(r.l)) a = a + 5'd1;
    end
    t.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a});
    return t;
  endfunction

  initial begin : mon
    vq_t tr;
    int idx;
    vec_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_act = 1'b0;
        exp_q.delete();
        hold_adr = 5'd0;
        continue;
      end
      cur = '{pre, in, sae, we, done, req_ready, {adr4, adr}};
      if (!mon_act && pre) begin
        if (exp_q.size() == 0) chk("unexpected_start", 32'(cur), 32'(0));
        else begin
          tr = build(T_PRE, T_WL, T_REC, exp_q.pop_front());
          mon_act = 1'b1;
          idx = 0;
        end
      end
      if (mon_act) begin
        chk("trace", 32'(cur), 32'(tr[idx]));
        idx++;
        if (idx == tr.size()) begin
          mon_act = 1'b0;
          hold_adr = tr[idx - 1].adr;
        end
      end else
        chk("idle", 32'(cur), 32'(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hold_adr}));
    end
  end

  // call at posedge+#1; returns at posedge+#1 after the handshake edge
  task automatic send(input logic [4:0] a, input logic w, input logic [3:0] l, input bit hold, input bit b2b);
    bit ok = 1'b0;
    req_valid = 1'b1; req_addr = a; req_wr = w; req_len_v = l;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      chk("hs_timeout", 32'(0), 32'(1));
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back('{a, w, BURST ? l : 4'd0});
    if (b2b) chk("spacing", 32'(cyc + 1 - last_hs), 32'(last_rows * BUSY + 1));
    last_hs = cyc + 1;
    last_rows = BURST ? int'(l) + 1 : 1;
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_addr = 5'($urandom);
      req_wr = 1'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || mon_act); i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()) + 32'(mon_act), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    send(5'($urandom), 1'($urandom), 4'd0, 1'b0, 1'b0);
    repeat (T_PRE + 1) @(posedge clk);
    #2;
    chk("in_before_rst", 32'(in), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({pre, in, sae, we, done, req_ready, adr4, adr}), 32'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fast_test();
    vq_t t;
    logic [4:0] a;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      a = 5'($urandom);
      f_valid = 1'b1; f_addr = a; f_wr = k[0];
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        ok = f_ready;
      end
      if (!ok) begin
        chk("fast_hs_timeout", 32'(0), 32'(1));
        f_valid = 1'b0;
        return;
      end
      t = build(1, 1, 1, '{a, k[0], 4'd0});
      @(posedge clk); #1;
      f_valid = 1'b0;
      foreach (t[i]) begin
        @(negedge clk);
        chk("fast_trace", 32'({f_pre, f_in, f_sae, f_we, f_done, f_ready, f_adr4, f_adr}), 32'(t[i]));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit hold, prev_hold;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({pre, in, sae, we, done, req_ready, adr4, adr}), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(req_ready), 32'(1));
    send(5'h03, 1'b0, 4'd0, 1'b0, 1'b0);
    drain();
    send(5'h1A, 1'b1, 4'd0, 1'b0, 1'b0);
    drain();
    send(5'h00, 1'b0, 4'd0, 1'b1, 1'b0);
    send(5'h0F, 1'b1, 4'd0, 1'b1, 1'b1);
    send(5'h10, 1'b0, 4'd0, 1'b0, 1'b1);
    drain();
    reset_mid();
    send(5'h07, 1'b0, 4'd0, 1'b0, 1'b0);
    drain();
    if (BURST) begin
      send(5'h1F, 1'b0, 4'd2, 1'b0, 1'b0);
      drain();
    end
    prev_hold = 1'b0;
    for (int n = 0; n < 40; n++) begin
      hold = n < 39 && $urandom_range(0, 2) == 0;
      send(5'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), hold, prev_hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      prev_hold = hold;
    end
    drain();
    fast_test();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
